// File: rtl/axi_lite_to_mem_pkg.sv
// Shared types and constants for the AXI4-Lite to req/gnt memory responder.
package axi_lite_to_mem_pkg;

    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_e;

    function automatic req_type_e other_type(input req_type_e t);
        return (t == REQ_READ) ? REQ_WRITE : REQ_READ;
    endfunction

endpackage

// File: rtl/axi_lite_to_mem_rsp_buf.sv
// Small synchronous FIFO with registered storage; used for request types and responses.
module axi_lite_to_mem_rsp_buf #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_lite_to_mem.sv
// AXI4-Lite responder: arbitrates AW/W and AR onto a req/gnt/rvalid memory port
// and returns B/R responses strictly in issue order.
module axi_lite_to_mem
    import axi_lite_to_mem_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    output logic [1:0]             b_resp_o,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  logic                   mem_err_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef struct packed {
        req_type_e              rtype;
        logic [DataWidth-1:0]   data;
        logic [RESP_W-1:0]      resp;
    } rsp_t;

    localparam int unsigned RspW = $bits(rsp_t);

    logic [CntW-1:0] cnt_q, cnt_d;
    req_type_e       prio_q, prio_d, lock_type_q, lock_type_d;
    logic            lock_q, lock_d;

    logic            wr_elig, rd_elig, has_req, grant, rsp_hs;
    req_type_e       sel;
    logic [0:0]      type_head_raw;
    req_type_e       type_head;
    logic            type_full, type_empty;
    rsp_t            rsp_in, rsp_head;
    logic [RspW-1:0] rsp_head_raw;
    logic            rsp_full, rsp_empty;

    assign wr_elig = aw_valid_i & w_valid_i;
    assign rd_elig = ar_valid_i;

    // While locked the stalled type wins regardless of priority.
    always_comb begin
        sel = REQ_READ;
        if (lock_q) begin
            sel = lock_type_q;
        end else if (wr_elig && rd_elig) begin
            sel = prio_q;
        end else if (wr_elig) begin
            sel = REQ_WRITE;
        end
    end

    assign has_req   = (sel == REQ_WRITE) ? wr_elig : rd_elig;
    assign mem_req_o = rst_ni & has_req & (cnt_q < CntW'(MaxOutstanding));
    assign grant     = mem_req_o & mem_gnt_i;

    assign aw_ready_o = grant & (sel == REQ_WRITE);
    assign w_ready_o  = grant & (sel == REQ_WRITE);
    assign ar_ready_o = grant & (sel == REQ_READ);

    assign mem_we_o    = (sel == REQ_WRITE);
    assign mem_addr_o  = mem_we_o ? aw_addr_i : ar_addr_i;
    assign mem_be_o    = mem_we_o ? w_strb_i : '1;
    assign mem_wdata_o = mem_we_o ? w_data_i : '0;

    axi_lite_to_mem_rsp_buf #(
        .Depth (MaxOutstanding),
        .Width (1)
    ) i_type_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (sel),
        .pop_i   (mem_rvalid_i),
        .data_o  (type_head_raw),
        .full_o  (type_full),
        .empty_o (type_empty)
    );

    assign type_head = req_type_e'(type_head_raw);

    always_comb begin
        rsp_in       = '0;
        rsp_in.rtype = type_head;
        rsp_in.data  = mem_rdata_i;
        rsp_in.resp  = mem_err_i ? RESP_SLVERR : RESP_OKAY;
    end

    axi_lite_to_mem_rsp_buf #(
        .Depth (MaxOutstanding),
        .Width (RspW)
    ) i_rsp_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (mem_rvalid_i),
        .data_i  (rsp_in),
        .pop_i   (rsp_hs),
        .data_o  (rsp_head_raw),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    assign rsp_head  = rsp_t'(rsp_head_raw);
    assign b_valid_o = ~rsp_empty & (rsp_head.rtype == REQ_WRITE);
    assign r_valid_o = ~rsp_empty & (rsp_head.rtype == REQ_READ);
    assign b_resp_o  = b_valid_o ? rsp_head.resp : RESP_OKAY;
    assign r_resp_o  = r_valid_o ? rsp_head.resp : RESP_OKAY;
    assign r_data_o  = r_valid_o ? rsp_head.data : '0;
    assign rsp_hs    = (b_valid_o & b_ready_i) | (r_valid_o & r_ready_i);

    always_comb begin
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        lock_d      = lock_q;
        lock_type_d = lock_type_q;
        if (grant && !rsp_hs) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (rsp_hs && !grant) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (grant) begin
            prio_d = other_type(sel);
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            lock_d      = 1'b1;
            lock_type_d = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            prio_q      <= REQ_READ;
            lock_q      <= 1'b0;
            lock_type_q <= REQ_READ;
        end else begin
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            lock_type_q <= lock_type_d;
        end
    end

    // Interface protocol checks.
    a_rvalid_no_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> !type_empty);
    a_gnt_without_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_gnt_i |-> mem_req_o);
    a_type_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(grant && type_full));
    a_rsp_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mem_rvalid_i && rsp_full));
    a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $past(aw_valid_i && !aw_ready_o) |-> aw_valid_i);
    a_w_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $past(w_valid_i && !w_ready_o) |-> w_valid_i);
    a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $past(ar_valid_i && !ar_ready_o) |-> ar_valid_i);

endmodule

// File: tb/tb_axi_lite_to_mem.sv
// Directed bench for axi_lite_to_mem with a one-cycle-latency memory responder.
module tb_axi_lite_to_mem;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [31:0] aw_addr_i;
    logic        aw_valid_i;
    logic        aw_ready_o;
    logic [31:0] w_data_i;
    logic [3:0]  w_strb_i;
    logic        w_valid_i;
    logic        w_ready_o;
    logic [1:0]  b_resp_o;
    logic        b_valid_o;
    logic        b_ready_i;
    logic [31:0] ar_addr_i;
    logic        ar_valid_i;
    logic        ar_ready_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_valid_o;
    logic        r_ready_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    logic        gnt_en;
    logic [31:0] nxt_rdata;
    logic        nxt_err;
    logic        grant_log[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk_i = ~clk_i;

    assign mem_gnt_i = mem_req_o & gnt_en;

    axi_lite_to_mem #(
        .AddrWidth      (32),
        .DataWidth      (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .aw_addr_i    (aw_addr_i),
        .aw_valid_i   (aw_valid_i),
        .aw_ready_o   (aw_ready_o),
        .w_data_i     (w_data_i),
        .w_strb_i     (w_strb_i),
        .w_valid_i    (w_valid_i),
        .w_ready_o    (w_ready_o),
        .b_resp_o     (b_resp_o),
        .b_valid_o    (b_valid_o),
        .b_ready_i    (b_ready_i),
        .ar_addr_i    (ar_addr_i),
        .ar_valid_i   (ar_valid_i),
        .ar_ready_o   (ar_ready_o),
        .r_data_o     (r_data_o),
        .r_resp_o     (r_resp_o),
        .r_valid_o    (r_valid_o),
        .r_ready_i    (r_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, then drive memory response and drop accepted valids.
    task automatic cyc();
        logic fire, aw_hs, ar_hs;
        @(negedge clk_i);
        fire  = mem_req_o & mem_gnt_i;
        aw_hs = aw_ready_o;
        ar_hs = ar_ready_o;
        if (fire) grant_log.push_back(mem_we_o);
        @(posedge clk_i);
        #1;
        mem_rvalid_i = fire;
        mem_rdata_i  = fire ? nxt_rdata : 32'h0;
        mem_err_i    = fire & nxt_err;
        if (aw_hs) begin
            aw_valid_i = 1'b0;
            w_valid_i  = 1'b0;
        end
        if (ar_hs) ar_valid_i = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) cyc();
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        aw_addr_i = '0; aw_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_valid_i = 1'b0;
        ar_addr_i = '0; ar_valid_i = 1'b0; b_ready_i = 1'b1; r_ready_i = 1'b1;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        gnt_en = 1'b1; nxt_rdata = '0; nxt_err = 1'b0;

        #2;
        rst_ni = 1'b0;
        repeat (2) cyc();
        chk1("rst_req", mem_req_o, 1'b0);
        chk1("rst_awready", aw_ready_o, 1'b0);
        chk1("rst_arready", ar_ready_o, 1'b0);
        chk1("rst_bvalid", b_valid_o, 1'b0);
        chk1("rst_rvalid", r_valid_o, 1'b0);
        chk32("rst_rdata", r_data_o, 32'h0);
        rst_ni = 1'b1;
        #1;

        // Single write
        aw_addr_i = 32'h10; aw_valid_i = 1'b1;
        w_data_i = 32'hDEAD_BEEF; w_strb_i = 4'hF; w_valid_i = 1'b1;
        b_ready_i = 1'b0;
        #1;
        chk1("t1_req", mem_req_o, 1'b1);
        chk1("t1_we", mem_we_o, 1'b1);
        chk32("t1_addr", mem_addr_o, 32'h10);
        chk32("t1_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk32("t1_be", 32'(mem_be_o), 32'hF);
        chk1("t1_awready", aw_ready_o, 1'b1);
        chk1("t1_wready", w_ready_o, 1'b1);
        cyc();
        chk1("t1_bvalid_early", b_valid_o, 1'b0);
        cyc();
        chk1("t1_bvalid", b_valid_o, 1'b1);
        chk32("t1_bresp", 32'(b_resp_o), 32'h0);
        chk1("t1_rvalid", r_valid_o, 1'b0);
        b_ready_i = 1'b1;
        cyc();
        chk1("t1_bvalid_pop", b_valid_o, 1'b0);

        // Read with memory error
        ar_addr_i = 32'h20; ar_valid_i = 1'b1;
        nxt_err = 1'b1; nxt_rdata = 32'h0; r_ready_i = 1'b0;
        #1;
        chk1("t2_we", mem_we_o, 1'b0);
        chk32("t2_addr", mem_addr_o, 32'h20);
        chk32("t2_be", 32'(mem_be_o), 32'hF);
        chk32("t2_wdata", mem_wdata_o, 32'h0);
        chk1("t2_arready", ar_ready_o, 1'b1);
        chk1("t2_awready", aw_ready_o, 1'b0);
        cyc();
        cyc();
        chk1("t2_rvalid", r_valid_o, 1'b1);
        chk32("t2_rresp", 32'(r_resp_o), 32'h2);
        chk32("t2_rdata", r_data_o, 32'h0);
        chk1("t2_bvalid", b_valid_o, 1'b0);
        r_ready_i = 1'b1; nxt_err = 1'b0;
        cyc();
        chk1("t2_rvalid_pop", r_valid_o, 1'b0);

        // Contention from reset: read first, then write, alternating
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            nxt_rdata = 32'hA0 + 32'(i);
            aw_addr_i = 32'h100 + 32'(i); w_data_i = 32'h5000 + 32'(i); w_strb_i = 4'hF;
            aw_valid_i = 1'b1; w_valid_i = 1'b1;
            ar_addr_i = 32'h200 + 32'(i); ar_valid_i = 1'b1;
            #1;
            chk1("t3_first_read", mem_we_o, 1'b0);
            chk1("t3_arready", ar_ready_o, 1'b1);
            cyc();
            chk1("t3_second_write", mem_we_o, 1'b1);
            chk1("t3_awready", aw_ready_o, 1'b1);
            cyc();
            chk1("t3_rvalid", r_valid_o, 1'b1);
            chk32("t3_rdata", r_data_o, 32'hA0 + 32'(i));
            cyc();
            chk1("t3_bvalid", b_valid_o, 1'b1);
            chk1("t3_rvalid_off", r_valid_o, 1'b0);
            cyc();
        end
        chk32("t3_ngrants", 32'(grant_log.size()), 32'd8);
        for (int j = 0; j < 8; j++) begin
            if (j < grant_log.size()) chk1("t3_alternate", grant_log[j], 1'(j % 2));
        end

        // Full stall with B back-pressure
        grant_log.delete();
        b_ready_i = 1'b0;
        aw_addr_i = 32'h300; w_data_i = 32'h1; aw_valid_i = 1'b1; w_valid_i = 1'b1;
        #1;
        chk1("t4_req0", mem_req_o, 1'b1);
        cyc();
        aw_addr_i = 32'h304; w_data_i = 32'h2; aw_valid_i = 1'b1; w_valid_i = 1'b1;
        #1;
        chk1("t4_req1", mem_req_o, 1'b1);
        cyc();
        aw_addr_i = 32'h308; w_data_i = 32'h3; aw_valid_i = 1'b1; w_valid_i = 1'b1;
        #1;
        chk1("t4_full_noreq", mem_req_o, 1'b0);
        chk1("t4_bvalid", b_valid_o, 1'b1);
        cyc();
        cyc();
        chk1("t4_still_noreq", mem_req_o, 1'b0);
        chk1("t4_no_awready", aw_ready_o, 1'b0);
        chk32("t4_two_grants", 32'(grant_log.size()), 32'd2);
        b_ready_i = 1'b1;
        cyc();
        chk1("t4_req_after_b", mem_req_o, 1'b1);
        chk1("t4_awready_after_b", aw_ready_o, 1'b1);
        chk32("t4_addr3", mem_addr_o, 32'h308);
        repeat (4) cyc();
        chk32("t4_three_grants", 32'(grant_log.size()), 32'd3);
        chk1("t4_drained", b_valid_o, 1'b0);

        // Grant stall: make write the priority type, then hold a read without grant
        ar_addr_i = 32'h3C; ar_valid_i = 1'b1;
        repeat (4) cyc();
        gnt_en = 1'b0;
        ar_addr_i = 32'h40; ar_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                aw_addr_i = 32'h50; w_data_i = 32'h55; w_strb_i = 4'h3;
                aw_valid_i = 1'b1; w_valid_i = 1'b1;
            end
            #1;
            chk32("t5_hold_addr", mem_addr_o, 32'h40);
            chk1("t5_hold_we", mem_we_o, 1'b0);
            chk1("t5_no_arready", ar_ready_o, 1'b0);
            cyc();
        end
        gnt_en = 1'b1;
        #1;
        chk1("t5_read_granted", ar_ready_o, 1'b1);
        chk32("t5_read_addr", mem_addr_o, 32'h40);
        cyc();
        chk1("t5_write_we", mem_we_o, 1'b1);
        chk32("t5_write_addr", mem_addr_o, 32'h50);
        chk32("t5_write_be", 32'(mem_be_o), 32'h3);
        chk1("t5_write_awready", aw_ready_o, 1'b1);
        repeat (4) cyc();

        // Reset with two transfers in flight
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        aw_addr_i = 32'h70; w_data_i = 32'h7; w_strb_i = 4'hF; aw_valid_i = 1'b1; w_valid_i = 1'b1;
        cyc();
        ar_addr_i = 32'h74; ar_valid_i = 1'b1;
        cyc();
        ar_addr_i = 32'h60; ar_valid_i = 1'b1; nxt_rdata = 32'h1234_5678;
        #1;
        chk1("t6_full_noreq", mem_req_o, 1'b0);
        chk1("t6_bvalid_before", b_valid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk1("t6_rst_bvalid", b_valid_o, 1'b0);
        chk1("t6_rst_rvalid", r_valid_o, 1'b0);
        chk1("t6_rst_req", mem_req_o, 1'b0);
        chk1("t6_rst_arready", ar_ready_o, 1'b0);
        chk1("t6_rst_awready", aw_ready_o, 1'b0);
        chk1("t6_rst_wready", w_ready_o, 1'b0);
        cyc();
        cyc();
        rst_ni = 1'b1; b_ready_i = 1'b1; r_ready_i = 1'b1;
        #1;
        chk1("t6_req_after", mem_req_o, 1'b1);
        chk32("t6_addr_after", mem_addr_o, 32'h60);
        chk1("t6_arready_after", ar_ready_o, 1'b1);
        cyc();
        cyc();
        chk1("t6_rvalid", r_valid_o, 1'b1);
        chk32("t6_rdata", r_data_o, 32'h1234_5678);
        chk32("t6_rresp", 32'(r_resp_o), 32'h0);
        chk1("t6_no_stale_b", b_valid_o, 1'b0);
        cyc();
        chk1("t6_rvalid_pop", r_valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
